// File: rtl/decoder8_pipe_pkg.sv
// Shared types and helpers for the registered binary-to-one-hot decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decoder_pkg;

    localparam int IN_W_DEF  = 3;
    localparam int OUT_W_DEF = 2 ** IN_W_DEF;

    // Buffer occupancy, 0..2 entries
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_FULL  = 2'd2;

    // Binary code to one-hot word: bit[code] set, all others clear
    function automatic logic [OUT_W_DEF-1:0] onehot(input logic [IN_W_DEF-1:0] code);
        logic [OUT_W_DEF-1:0] w;
        w       = '0;
        w[code] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/decoder8_pipe_if.sv
// Input code and output one-hot valid/ready channels of the decoder.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready carry the usual valid/ready semantics.
interface decoder8_pipe_if #(
    parameter int IN_W = 3
);
    localparam int OUT_W = 2 ** IN_W;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_onehot;

    // Producer of codes / consumer of one-hot words
    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_onehot
    );

    // The decoder itself
    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_onehot
    );

endinterface

// File: rtl/decoder8_pipe_skid_buf.sv
// Two-entry FIFO holding decoded words between the input and output handshakes.
// Latency: 1 cycle from push to head; head is a plain register mux.
// Backpressure: pushes beyond two entries and pops from empty are ignored.
module decoder_skid_buf
    import decoder_pkg::*;
#(
    parameter int W = OUT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output occ_t         occ,
    output logic [W-1:0] head_dat
);

    logic [W-1:0] ent0_q;
    logic [W-1:0] ent1_q;
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    occ_t         occ_q;
    occ_t         occ_d;
    logic         push;
    logic         pop;

    // Guard against overflow/underflow so the pointers can never slip
    assign push = push_vld && (occ_q != OCC_FULL);
    assign pop  = pop_rdy  && (occ_q != OCC_EMPTY);

    // Occupancy next state: a simultaneous push and pop leaves it unchanged
    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (!push && pop) begin
            occ_d = occ_q - 2'd1;
        end
    end

    // Storage and pointers; reset also clears the entries so nothing stale is visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q   <= '0;
            ent1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= OCC_EMPTY;
        end else begin
            if (push) begin
                if (wr_ptr_q) begin
                    ent1_q <= push_dat;
                end else begin
                    ent0_q <= push_dat;
                end
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign occ      = occ_q;
    assign head_dat = rd_ptr_q ? ent1_q : ent0_q;

endmodule

// File: rtl/decoder8_pipe.sv
// Registered binary-to-one-hot decoder with enable gating and a saturating decode count.
// Latency: 1 cycle from accepted code to out_valid.
// Backpressure: 2-entry skid buffer; in_ready = en & not-full, independent of out_ready.
module decoder8_pipe
    import decoder_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] decode_cnt,
    decoder8_pipe_if.slave   bus
);

    localparam int               OUT_W   = 2 ** IN_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [OUT_W-1:0] dec_dat;
    logic [OUT_W-1:0] head_dat;
    occ_t             occ;
    logic             in_rdy;
    logic             accept;
    logic             out_vld;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Use the shared helper at the native width; fall back to a shift otherwise
    generate
        if (IN_W == IN_W_DEF) begin : g_dec_pkg
            assign dec_dat = onehot(bus.in_code);
        end else begin : g_dec_gen
            assign dec_dat = OUT_W'(1) << bus.in_code;
        end
    endgenerate

    // Ready depends only on registered occupancy and en, never on out_ready
    assign in_rdy       = en && (occ != OCC_FULL);
    assign accept       = bus.in_valid && in_rdy;
    assign out_vld      = (occ != OCC_EMPTY);
    assign bus.in_ready = in_rdy;
    assign bus.out_valid = out_vld;
    // Force zero when idle so the output is never a stale word
    assign bus.out_onehot = out_vld ? head_dat : '0;

    decoder_skid_buf #(
        .W (OUT_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (accept),
        .push_dat (dec_dat),
        .pop_rdy  (bus.out_ready),
        .occ      (occ),
        .head_dat (head_dat)
    );

    // Count next state: clear wins over a same-cycle accept; saturate at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign decode_cnt = cnt_q;

endmodule

// File: tb/tb_decoder8_pipe.sv
// Self-checking bench for decoder8_pipe: directed table, corner sequences, random run.
// Two instances share stimulus: 16-bit count and 4-bit count (for saturation).
// Reference model is a queue of accepted codes plus integer counters.
module tb_decoder8_pipe;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        cnt_clr;
    logic [15:0] decode_cnt_a;
    logic [3:0]  decode_cnt_b;

    decoder8_pipe_if #(.IN_W(3)) bus_a ();
    decoder8_pipe_if #(.IN_W(3)) bus_b ();

    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.in_code   = bus_a.in_code;
    assign bus_b.out_ready = bus_a.out_ready;

    decoder8_pipe #(.IN_W(3), .CNT_W(16)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cnt_clr    (cnt_clr),
        .decode_cnt (decode_cnt_a),
        .bus        (bus_a)
    );

    decoder8_pipe #(.IN_W(3), .CNT_W(4)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cnt_clr    (cnt_clr),
        .decode_cnt (decode_cnt_b),
        .bus        (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] code;
        logic [7:0] exp;
    } vec_t;

    vec_t       tv [8];
    logic [2:0] mq [$];
    int         m_cnt_a;
    int         m_cnt_b;
    int         checks;
    int         errors;
    int         cnt_before;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Encoder8: index of the set bit of a one-hot word
    function automatic logic [31:0] enc8(input logic [7:0] oh);
        logic [31:0] r;
        r = 32'hFF;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

    task automatic check_outputs();
        int n;
        logic [31:0] exp_oh;
        n      = mq.size();
        exp_oh = (n != 0) ? (32'd1 << mq[0]) : 32'd0;
        chk("in_ready",   bus_a.in_ready,   (en && n < 2) ? 1 : 0);
        chk("out_valid",  bus_a.out_valid,  (n != 0) ? 1 : 0);
        chk("out_onehot", bus_a.out_onehot, exp_oh);
        chk("b_onehot",   bus_b.out_onehot, exp_oh);
        if (n != 0) chk("round_trip", enc8(bus_a.out_onehot), mq[0]);
        chk("cnt16", decode_cnt_a, m_cnt_a);
        chk("cnt4",  decode_cnt_b, m_cnt_b);
    endtask

    // Advance the model using the inputs present just before the edge
    task automatic model_update();
        logic rdy;
        logic acc;
        rdy = en && (mq.size() < 2);
        acc = bus_a.in_valid && rdy;
        if (mq.size() != 0 && bus_a.out_ready) void'(mq.pop_front());
        if (acc) mq.push_back(bus_a.in_code);
        if (cnt_clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (acc) begin
            if (m_cnt_a < 65535) m_cnt_a++;
            if (m_cnt_b < 15)    m_cnt_b++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic r);
        bus_a.in_valid  = v;
        bus_a.in_code   = v ? c : 3'bxxx;
        bus_a.out_ready = r;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_cnt_a = 0;
        m_cnt_b = 0;
        tv[0] = '{3'd0, 8'h01};
        tv[1] = '{3'd4, 8'h10};
        tv[2] = '{3'd6, 8'h40};
        tv[3] = '{3'd7, 8'h80};
        tv[4] = '{3'd1, 8'h02};
        tv[5] = '{3'd2, 8'h04};
        tv[6] = '{3'd3, 8'h08};
        tv[7] = '{3'd5, 8'h20};

        // Reset state
        rst_n   = 1'b0;
        en      = 1'b1;
        cnt_clr = 1'b0;
        drive(1'b0, 3'd0, 1'b1);
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1. Table: back-to-back codes, each visible one cycle after accept
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tv[i].code, 1'b1);
            step();
            chk("tbl_oh", bus_a.out_onehot, tv[i].exp);
            chk("tbl_rt", enc8(bus_a.out_onehot), tv[i].code);
            if (i == 3) chk("cnt_after4", decode_cnt_a, 4);
        end
        drive(1'b0, 3'd0, 1'b1);
        step();

        // 2. Fill with out_ready=0, third code stalls, then drains in order
        drive(1'b1, 3'd1, 1'b0); step();
        drive(1'b1, 3'd2, 1'b0); step();
        drive(1'b1, 3'd3, 1'b0); step();
        chk("full_rdy", bus_a.in_ready, 0);
        step();
        drive(1'b1, 3'd3, 1'b1);
        step();
        chk("drain1", bus_a.out_onehot, 8'h04);
        step();
        drive(1'b0, 3'd0, 1'b1);
        chk("drain2", bus_a.out_onehot, 8'h08);
        step();

        // 3. Hold a word for 5 cycles with out_ready=0
        drive(1'b1, 3'd5, 1'b0); step();
        drive(1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_oh",  bus_a.out_onehot, 8'h20);
            chk("hold_vld", bus_a.out_valid, 1);
        end
        drive(1'b0, 3'd0, 1'b1); step();

        // 4. en=0 with two entries buffered: drain, no accepts, count frozen
        drive(1'b1, 3'd6, 1'b0); step();
        drive(1'b1, 3'd1, 1'b0); step();
        en = 1'b0;
        cnt_before = m_cnt_a;
        drive(1'b1, 3'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en0_rdy", bus_a.in_ready, 0);
            chk("en0_cnt", decode_cnt_a, cnt_before);
        end
        chk("en0_empty", bus_a.out_valid, 0);
        en = 1'b1;

        // 5. Saturation of the 4-bit count, then clear beating an accept
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 1'b1);
            step();
        end
        chk("sat4", decode_cnt_b, 15);
        cnt_clr = 1'b1;
        drive(1'b1, 3'd2, 1'b1);
        step();
        cnt_clr = 1'b0;
        chk("clr_b", decode_cnt_b, 0);
        chk("clr_a", decode_cnt_a, 0);
        drive(1'b0, 3'd0, 1'b1);
        step();

        // 6. Asynchronous reset with one entry buffered
        drive(1'b1, 3'd3, 1'b0); step();
        drive(1'b0, 3'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", bus_a.out_valid, 0);
        chk("arst_oh",  bus_a.out_onehot, 0);
        chk("arst_cnt", decode_cnt_a, 0);
        mq.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 3'd7, 1'b1);
        step();
        chk("post_rst", bus_a.out_onehot, 8'h80);

        // Random run against the queue model
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 7) != 0);
            cnt_clr = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0);
            step();
        end
        cnt_clr = 1'b0;
        drive(1'b0, 3'd0, 1'b1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
